// File: rtl/vx_operand_collector.sv
// Banked operand collector: NUM_COLLECTORS units share NUM_BANKS GPR banks through per-bank round-robin read arbitration.
// Macros: VX_OPC_WB_FWD_EN forwards same-cycle writeback into reads; GPR_RESET zeroes the GPR RAM on reset.

// state   | meaning
// S_IDLE  | free, can accept an instruction
// S_FETCH | operands pending or being read from the banks
// S_READY | all operands captured, competing for the output
module vx_operand_collector #(
   parameter  int NUM_COLLECTORS = 4,
   parameter  int NUM_BANKS      = 4,
   parameter  int NUM_SRC_OPDS   = 3,
   parameter  int NUM_REGS       = 32,
   parameter  int NUM_WARPS      = 4,
   parameter  int NUM_THREADS    = 4,
   parameter  int XLEN           = 32,
   parameter  int META_W         = 64,
   localparam int NR_BITS        = $clog2(NUM_REGS),
   localparam int WIS_W          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [WIS_W-1:0]                          in_wis,
   input  logic [NUM_SRC_OPDS*NR_BITS-1:0]           in_rs,
   input  logic [META_W-1:0]                         in_meta,
   input  logic                                      wb_valid,
   input  logic [WIS_W-1:0]                          wb_wis,
   input  logic [NR_BITS-1:0]                        wb_rd,
   input  logic [NUM_THREADS-1:0]                    wb_tmask,
   input  logic [NUM_THREADS*XLEN-1:0]               wb_data,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [WIS_W-1:0]                          out_wis,
   output logic [META_W-1:0]                         out_meta,
   output logic [NUM_SRC_OPDS*NUM_THREADS*XLEN-1:0]  out_data
);
   localparam int BB    = $clog2(NUM_BANKS);
   localparam int BIW   = (BB > 0) ? BB : 1;
   localparam int CW    = (NUM_COLLECTORS > 1) ? $clog2(NUM_COLLECTORS) : 1;
   localparam int OW    = (NUM_SRC_OPDS > 1) ? $clog2(NUM_SRC_OPDS) : 1;
   localparam int DEPTH = (NUM_REGS / NUM_BANKS) << WIS_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int DW    = NUM_THREADS * XLEN;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY} state_e;

   state_e             state_q [NUM_COLLECTORS], state_d [NUM_COLLECTORS];
   logic [WIS_W-1:0]   wis_q   [NUM_COLLECTORS], wis_d   [NUM_COLLECTORS];
   logic [META_W-1:0]  meta_q  [NUM_COLLECTORS], meta_d  [NUM_COLLECTORS];
   logic [NR_BITS-1:0] rs_q    [NUM_COLLECTORS][NUM_SRC_OPDS], rs_d [NUM_COLLECTORS][NUM_SRC_OPDS];
   logic [DW-1:0]      data_q  [NUM_COLLECTORS][NUM_SRC_OPDS], data_d [NUM_COLLECTORS][NUM_SRC_OPDS];
   logic [NUM_SRC_OPDS-1:0] pend_q [NUM_COLLECTORS], pend_d [NUM_COLLECTORS];

   logic [NUM_BANKS-1:0] rd_vld_q, rd_vld_d, rd_en;
   logic [CW-1:0]  rd_col_q [NUM_BANKS], rd_col_d [NUM_BANKS], gnt_col [NUM_BANKS];
   logic [OW-1:0]  rd_opd_q [NUM_BANKS], rd_opd_d [NUM_BANKS], gnt_opd [NUM_BANKS];
   logic [CW-1:0]  rr_q [NUM_BANKS], rr_d [NUM_BANKS];
   logic [AW-1:0]  raddr [NUM_BANKS];
   logic [DW-1:0]  rdata_q [NUM_BANKS], rdata_d [NUM_BANKS];
   logic [DW-1:0]  gpr_mem [NUM_BANKS][DEPTH];

   logic [CW-1:0]  out_rr_q, out_rr_d, hold_col_q, hold_col_d, out_col, acc_col;
   logic           hold_q, hold_d, out_found, fire;
   int             arb_c, out_c;

   function automatic logic [BIW-1:0] bank_of(input logic [NR_BITS-1:0] r);
      return BIW'(32'(r) % NUM_BANKS);
   endfunction

   function automatic logic [AW-1:0] addr_of(input logic [NR_BITS-1:0] r, input logic [WIS_W-1:0] w);
      return AW'(((32'(r) >> BB) << WIS_W) | 32'(w));
   endfunction

   logic [BIW-1:0] wb_bank;
   logic [AW-1:0]  wb_addr;
   assign wb_bank = bank_of(wb_rd);
   assign wb_addr = addr_of(wb_rd, wb_wis);

   always_comb begin
      acc_col  = '0;
      in_ready = 1'b0;
      for (int c = NUM_COLLECTORS - 1; c >= 0; c--) begin
         if (state_q[c] == S_IDLE) begin
            acc_col  = CW'(c);
            in_ready = 1'b1;
         end
      end
   end

   // Per bank: rotate from rr_q to the first FETCH collector with a pending operand here.
   always_comb begin
      arb_c = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         rd_en[b]   = 1'b0;
         gnt_col[b] = '0;
         gnt_opd[b] = '0;
         raddr[b]   = '0;
         for (int k = 0; k < NUM_COLLECTORS; k++) begin
            arb_c = (int'(rr_q[b]) + k) % NUM_COLLECTORS;
            for (int o = 0; o < NUM_SRC_OPDS; o++) begin
               if (!rd_en[b] && state_q[arb_c] == S_FETCH && pend_q[arb_c][o] &&
                   bank_of(rs_q[arb_c][o]) == BIW'(b)) begin
                  rd_en[b]   = 1'b1;
                  gnt_col[b] = CW'(arb_c);
                  gnt_opd[b] = OW'(o);
                  raddr[b]   = addr_of(rs_q[arb_c][o], wis_q[arb_c]);
               end
            end
         end
      end
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         rdata_d[b] = rdata_q[b];
         if (rd_en[b]) begin
            rdata_d[b] = gpr_mem[b][raddr[b]];
`ifdef VX_OPC_WB_FWD_EN
            if (wb_valid && wb_bank == BIW'(b) && wb_addr == raddr[b]) begin
               for (int t = 0; t < NUM_THREADS; t++) begin
                  if (wb_tmask[t]) rdata_d[b][t*XLEN +: XLEN] = wb_data[t*XLEN +: XLEN];
               end
            end
`endif
         end
      end
   end

   // A stalled winner is held so a newly READY collector cannot displace it.
   always_comb begin
      out_c     = 0;
      out_found = hold_q;
      out_col   = hold_col_q;
      for (int k = 0; k < NUM_COLLECTORS; k++) begin
         out_c = (int'(out_rr_q) + k) % NUM_COLLECTORS;
         if (!out_found && state_q[out_c] == S_READY) begin
            out_found = 1'b1;
            out_col   = CW'(out_c);
         end
      end
      fire      = out_found && out_ready;
      out_valid = out_found;
      out_wis   = '0;
      out_meta  = '0;
      out_data  = '0;
      if (out_found) begin
         out_wis  = wis_q[out_col];
         out_meta = meta_q[out_col];
         for (int o = 0; o < NUM_SRC_OPDS; o++) out_data[o*DW +: DW] = data_q[out_col][o];
      end
   end

   always_comb begin
      state_d    = state_q;
      wis_d      = wis_q;
      meta_d     = meta_q;
      rs_d       = rs_q;
      data_d     = data_q;
      pend_d     = pend_q;
      rr_d       = rr_q;
      rd_vld_d   = rd_en;
      rd_col_d   = gnt_col;
      rd_opd_d   = gnt_opd;
      out_rr_d   = out_rr_q;
      hold_d     = out_found && !out_ready;
      hold_col_d = out_col;

      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rd_en[b]) begin
            pend_d[gnt_col[b]][gnt_opd[b]] = 1'b0;
            rr_d[b] = CW'((int'(gnt_col[b]) + 1) % NUM_COLLECTORS);
         end
         if (rd_vld_q[b]) data_d[rd_col_q[b]][rd_opd_q[b]] = rdata_q[b];
      end

      // Reads complete in one cycle, so pend_q==0 means the last capture happens this cycle.
      for (int c = 0; c < NUM_COLLECTORS; c++) begin
         if (state_q[c] == S_FETCH && pend_q[c] == '0) state_d[c] = S_READY;
      end

      if (fire) begin
         state_d[out_col] = S_IDLE;
         out_rr_d = CW'((int'(out_col) + 1) % NUM_COLLECTORS);
      end

      if (in_valid && in_ready) begin
         state_d[acc_col] = S_FETCH;
         wis_d[acc_col]   = in_wis;
         meta_d[acc_col]  = in_meta;
         for (int o = 0; o < NUM_SRC_OPDS; o++) begin
            rs_d[acc_col][o]   = in_rs[o*NR_BITS +: NR_BITS];
            pend_d[acc_col][o] = (in_rs[o*NR_BITS +: NR_BITS] != '0);
            data_d[acc_col][o] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= '{default: S_IDLE};
         pend_q     <= '{default: '0};
         rr_q       <= '{default: '0};
         rd_vld_q   <= '0;
         out_rr_q   <= '0;
         hold_q     <= 1'b0;
         hold_col_q <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         rr_q       <= rr_d;
         rd_vld_q   <= rd_vld_d;
         out_rr_q   <= out_rr_d;
         hold_q     <= hold_d;
         hold_col_q <= hold_col_d;
      end
   end

   always_ff @(posedge clk) begin
      wis_q    <= wis_d;
      meta_q   <= meta_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      rd_col_q <= rd_col_d;
      rd_opd_q <= rd_opd_d;
      rdata_q  <= rdata_d;
   end

   always_ff @(posedge clk) begin
`ifdef GPR_RESET
      if (reset) begin
         for (int b = 0; b < NUM_BANKS; b++)
            for (int a = 0; a < DEPTH; a++) gpr_mem[b][a] <= '0;
      end else
`endif
      if (wb_valid) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (wb_tmask[t]) gpr_mem[wb_bank][wb_addr][t*XLEN +: XLEN] <= wb_data[t*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: tb/tb_vx_operand_collector.sv
// Self-checking bench for vx_operand_collector: directed timing cases plus randomized traffic against a register-file model.
module tb_vx_operand_collector;
   localparam int NR_BITS = 5;
   localparam int WIS_W   = 2;
   localparam int NT      = 4;
   localparam int XLEN    = 32;
   localparam int NSO     = 3;
   localparam int DW      = NT * XLEN;
   localparam int OUT_W   = NSO * DW;
   localparam int N_RND   = 40;

   logic clk, reset;
   logic in_valid, in_ready;
   logic [WIS_W-1:0] in_wis;
   logic [NSO*NR_BITS-1:0] in_rs;
   logic [63:0] in_meta;
   logic wb_valid;
   logic [WIS_W-1:0] wb_wis;
   logic [NR_BITS-1:0] wb_rd;
   logic [NT-1:0] wb_tmask;
   logic [DW-1:0] wb_data;
   logic out_valid, out_ready;
   logic [WIS_W-1:0] out_wis;
   logic [63:0] out_meta;
   logic [OUT_W-1:0] out_data;

   vx_operand_collector dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis), .in_rs(in_rs), .in_meta(in_meta),
      .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_wis(out_wis), .out_meta(out_meta), .out_data(out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] gpr [4][32][NT];

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OUT_W-1:0] exp_ops(input int w, input int r0, input int r1, input int r2);
      logic [OUT_W-1:0] v;
      int r [NSO];
      v = '0;
      r[0] = r0; r[1] = r1; r[2] = r2;
      for (int o = 0; o < NSO; o++)
         for (int t = 0; t < NT; t++)
            v[(o*NT+t)*XLEN +: XLEN] = (r[o] == 0) ? 32'h0 : gpr[w][r[o]][t];
      return v;
   endfunction

   task automatic wr(input int w, input int r, input logic [NT-1:0] tm, input logic [DW-1:0] d);
      wb_valid = 1'b1; wb_wis = WIS_W'(w); wb_rd = NR_BITS'(r); wb_tmask = tm; wb_data = d;
      step();
      wb_valid = 1'b0;
      for (int t = 0; t < NT; t++) if (tm[t]) gpr[w][r][t] = d[t*XLEN +: XLEN];
   endtask

   task automatic wr_all(input int w, input int r, input logic [31:0] v);
      wr(w, r, 4'hF, {NT{v}});
   endtask

   task automatic drive_in(input int w, input int r0, input int r1, input int r2, input logic [63:0] m);
      in_wis  = WIS_W'(w);
      in_rs   = {NR_BITS'(r2), NR_BITS'(r1), NR_BITS'(r0)};
      in_meta = m;
   endtask

   task automatic issue(input int w, input int r0, input int r1, input int r2, input logic [63:0] m);
      int n;
      drive_in(w, r0, r1, r2, m);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin step(); n++; end
      if (!in_ready) check("issue_timeout", 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
   endtask

   // lat = number of clock edges from the accept edge to the first sample with out_valid.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 60) begin step(); lat++; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
`ifdef GPR_RESET
      for (int w = 0; w < 4; w++) for (int r = 0; r < 32; r++) for (int t = 0; t < NT; t++) gpr[w][r][t] = 32'h0;
`endif
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, issued, done, id;
      bit stale, accept;
      bit got [N_RND];
      logic [OUT_W-1:0] exp_d [N_RND];
      logic [WIS_W-1:0] exp_w [N_RND];
      logic [OUT_W-1:0] e;
      int rw, rr0, rr1, rr2;

      for (int w = 0; w < 4; w++) for (int r = 0; r < 32; r++) for (int t = 0; t < NT; t++) gpr[w][r][t] = 32'h0;
      in_valid = 0; in_wis = 0; in_rs = 0; in_meta = 0;
      wb_valid = 0; wb_wis = 0; wb_rd = 0; wb_tmask = 0; wb_data = 0;
      out_ready = 0;
      do_reset();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_meta", out_meta, 64'h0);
      check("rst_out_data", out_data, '0);
      check("rst_out_wis", out_wis, '0);

      // conflict-free
      out_ready = 1'b1;
      wr_all(0, 1, 32'h11); wr_all(0, 2, 32'h22); wr_all(0, 3, 32'h33);
      issue(0, 1, 2, 3, 64'h100);
      wait_out(lat);
      check("cf_lat", lat, 3);
      check("cf_data", out_data, {{NT{32'h33}}, {NT{32'h22}}, {NT{32'h11}}});
      check("cf_meta", out_meta, 64'h100);
      step();

      // intra-instruction bank conflict
      wr_all(0, 4, 32'h44); wr_all(0, 8, 32'h88); wr_all(0, 12, 32'hCC);
      issue(0, 4, 8, 12, 64'h101);
      wait_out(lat);
      check("bank_conf_lat", lat, 5);
      check("bank_conf_data", out_data, exp_ops(0, 4, 8, 12));
      step();

      // zero registers
      wr_all(1, 5, 32'h5555_0005);
      issue(1, 0, 0, 5, 64'h102);
      wait_out(lat);
      check("zero_lat", lat, 3);
      check("zero_data", out_data, {{NT{32'h5555_0005}}, {(2*DW){1'b0}}});
      check("zero_wis", out_wis, 2'd1);
      step();
      issue(2, 0, 0, 0, 64'h103);
      wait_out(lat);
      check("allzero_lat", lat, 2);
      check("allzero_data", out_data, '0);
      step();

      // same-cycle write and read of r6
      wr_all(0, 6, 32'h55);
      issue(0, 6, 0, 0, 64'h104);
      wb_valid = 1'b1; wb_wis = 0; wb_rd = 5'd6; wb_tmask = 4'b0101; wb_data = {NT{32'hAA}};
      step();
      wb_valid = 1'b0;
`ifdef VX_OPC_WB_FWD_EN
      e = {{(2*DW){1'b0}}, 32'h55, 32'hAA, 32'h55, 32'hAA};
`else
      e = {{(2*DW){1'b0}}, {NT{32'h55}}};
`endif
      for (int t = 0; t < NT; t++) if (t % 2 == 0) gpr[0][6][t] = 32'hAA;
      wait_out(lat);
      check("wb_rd_lat", lat, 2);
      check("wb_rd_data", out_data, e);
      step();

      // cross-collector contention on bank 1
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wr_all(k, 1, 32'h1000*k + 1); wr_all(k, 5, 32'h1000*k + 5); wr_all(k, 9, 32'h1000*k + 9);
      end
      for (int k = 0; k < 4; k++) issue(k, 1, 5, 9, 64'h200 + 64'(k));
      check("cont_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 20; i++) step();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("cont_valid", out_valid, 1'b1);
         check("cont_meta", out_meta, 64'h200 + 64'(k));
         check("cont_data", out_data, exp_ops(k, 1, 5, 9));
         step();
      end
      check("cont_drained", out_valid, 1'b0);

      // output backpressure with two READY collectors
      out_ready = 1'b0;
      wr_all(0, 7, 32'h77); wr_all(1, 7, 32'h7171);
      issue(0, 7, 0, 0, 64'h300);
      issue(1, 7, 0, 0, 64'h301);
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", out_valid, 1'b1);
         check("bp_meta", out_meta, 64'h300);
         check("bp_data", out_data, exp_ops(0, 7, 0, 0));
         step();
      end
      out_ready = 1'b1;
      check("bp_rel0", out_meta, 64'h300);
      step();
      check("bp_rel1_valid", out_valid, 1'b1);
      check("bp_rel1", out_meta, 64'h301);
      check("bp_rel1_data", out_data, exp_ops(1, 7, 0, 0));
      step();
      check("bp_empty", out_valid, 1'b0);

      // reset while two collectors are in FETCH
      issue(0, 4, 8, 12, 64'h400);
      issue(1, 4, 8, 12, 64'h401);
      reset = 1'b1;
      step();
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_valid", out_valid, 1'b0);
      reset = 1'b0;
`ifdef GPR_RESET
      for (int w = 0; w < 4; w++) for (int r = 0; r < 32; r++) for (int t = 0; t < NT; t++) gpr[w][r][t] = 32'h0;
`endif
      stale = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid || !in_ready) stale = 1'b1;
         step();
      end
      check("midrst_no_stale", stale, 1'b0);

      // randomized traffic, no writes while instructions are outstanding
      do_reset();
      for (int w = 0; w < 4; w++) for (int r = 1; r < 32; r++) wr_all(w, r, $urandom);
      for (int i = 0; i < 8; i++) wr($urandom_range(0, 3), $urandom_range(1, 31), 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < N_RND; i++) got[i] = 1'b0;
      issued = 0; done = 0; n = 0;
      while (done < N_RND && n < 4000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && issued < N_RND && $urandom_range(0, 1) == 1) begin
            rw  = $urandom_range(0, 3);
            rr0 = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31);
            rr1 = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31);
            rr2 = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31);
            drive_in(rw, rr0, rr1, rr2, 64'hCAFE_0000_0000_0000 | 64'(issued));
            exp_d[issued] = exp_ops(rw, rr0, rr1, rr2);
            exp_w[issued] = WIS_W'(rw);
            in_valid = 1'b1;
         end
         accept = in_valid && in_ready;
         if (out_valid && out_ready) begin
            id = int'(out_meta[31:0]);
            if (id < N_RND && id < issued + (accept ? 1 : 0) && !got[id]) begin
               check("rnd_data", out_data, exp_d[id]);
               check("rnd_wis", out_wis, exp_w[id]);
               got[id] = 1'b1;
            end else begin
               check("rnd_id", out_meta, 64'hCAFE_0000_0000_0000 | 64'(done));
            end
            done++;
         end
         step();
         n++;
         if (accept) begin
            issued++;
            in_valid = 1'b0;
         end
      end
      check("rnd_done", done, N_RND);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
